// File: rtl/cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache between a CPU load/store port
// and a request/acknowledge memory bus, with bulk flush and saturating hit/miss counters.
module cache_dm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int LOC_W = OFF_W + IDX_W;
  localparam int TAG_W = ADDR_WIDTH - LOC_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_WRITE  = 2'd3;

  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] BEAT_ZERO = OFF_W'(0);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [15:0]           hit_cnt_q, hit_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem [NUM_LINES];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [TAG_W-1:0]      rd_tag_q;

  logic [TAG_W-1:0]      tag_s;
  logic [IDX_W-1:0]      idx_s;
  logic [OFF_W-1:0]      off_s;
  logic                  cpu_ready_s;
  logic                  accept_s;
  logic                  ack_s;
  logic                  hit_s;
  logic                  arr_we_s;
  logic [LOC_W-1:0]      arr_waddr_s;
  logic [DATA_WIDTH-1:0] arr_wdata_s;
  logic                  tag_we_s;

  assign tag_s       = addr_q[ADDR_WIDTH-1:LOC_W];
  assign idx_s       = addr_q[LOC_W-1:OFF_W];
  assign off_s       = addr_q[OFF_W-1:0];
  assign cpu_ready_s = (state_q == S_IDLE) && !flush;
  assign accept_s    = cpu_req && cpu_ready_s;
  // An ack only counts while a request is actually outstanding.
  assign ack_s       = mem_ack && mem_req_q;
  assign hit_s       = valid_q[idx_s] && (rd_tag_q == tag_s);

  // Next-state and datapath decisions for the controller.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    hold_d       = hold_q;
    valid_d      = valid_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    arr_we_s     = 1'b0;
    arr_waddr_s  = {LOC_W{1'b0}};
    arr_wdata_s  = {DATA_WIDTH{1'b0}};
    tag_we_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = {NUM_LINES{1'b0}};
        end else if (accept_s) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
        if (we_q) begin
          // Write-through: update the line only on a hit, always forward to memory.
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          if (hit_s) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = addr_q[LOC_W-1:0];
            arr_wdata_s = wdata_q;
          end else begin
            arr_we_s = 1'b0;
          end
        end else if (hit_s) begin
          cpu_rdata_d  = rd_data_q;
          cpu_rvalid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          beat_d     = BEAT_ZERO;
          state_d    = S_FILL;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_s, idx_s, BEAT_ZERO};
        end
      end
      S_FILL: begin
        if (ack_s) begin
          arr_we_s    = 1'b1;
          arr_waddr_s = {idx_s, beat_q};
          arr_wdata_s = mem_rdata;
          if (beat_q == off_s) begin
            hold_d = mem_rdata;
          end else begin
            hold_d = hold_q;
          end
          if (beat_q == BEAT_LAST) begin
            tag_we_s       = 1'b1;
            valid_d[idx_s] = 1'b1;
            cpu_rdata_d    = (beat_q == off_s) ? mem_rdata : hold_q;
            cpu_rvalid_d   = 1'b1;
            mem_req_d      = 1'b0;
            beat_d         = BEAT_ZERO;
            state_d        = S_IDLE;
          end else begin
            beat_d     = beat_q + BEAT_ONE;
            mem_addr_d = {tag_s, idx_s, beat_q + BEAT_ONE};
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITE: begin
        if (ack_s) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      we_q         <= 1'b0;
      wdata_q      <= {DATA_WIDTH{1'b0}};
      beat_q       <= BEAT_ZERO;
      hold_q       <= {DATA_WIDTH{1'b0}};
      valid_q      <= {NUM_LINES{1'b0}};
      hit_cnt_q    <= 16'd0;
      miss_cnt_q   <= 16'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      hold_q       <= hold_d;
      valid_q      <= valid_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Data and tag arrays: read launched at acceptance, consumed during LOOKUP.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      rd_data_q <= data_mem[cpu_addr[LOC_W-1:0]];
      rd_tag_q  <= tag_mem[cpu_addr[LOC_W-1:OFF_W]];
    end
    if (arr_we_s) begin
      data_mem[arr_waddr_s] <= arr_wdata_s;
    end
    if (tag_we_s) begin
      tag_mem[idx_s] <= tag_s;
    end
  end

  assign cpu_ready  = cpu_ready_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: doc/cache_dm.md
# cache_dm

Parametrised direct-mapped CPU cache with tag/valid tracking, line fill from backing memory and write-through stores. Sits between the core's load/store path and the memory bus. Replaces the flat tagless byte bank with real hit/miss detection, a valid-handshake CPU port, a request/acknowledge memory port, bulk flush and hit/miss statistics.

## Interface
- ADDR_WIDTH, 16: CPU and memory address width.
- DATA_WIDTH, 8: data word width; one word per address.
- LINE_WORDS, 4: words per line; power of two, ≥2.
- NUM_LINES, 64: number of lines; power of two, ≥2. Requires log2(LINE_WORDS)+log2(NUM_LINES) < ADDR_WIDTH.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_ready  out  1  request accepted on edge where cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse, load data valid.
- cpu_rdata  out  DATA_WIDTH  load data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completes current request this edge.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

## Operation
- Address split: offset = low log2(LINE_WORDS) bits, index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Storage: data array NUM_LINES×LINE_WORDS words (synchronous read, no reset); tag array; valid bit vector in flops.
- FSM states IDLE, LOOKUP, FILL, WRITE.
- IDLE: cpu_ready = !flush. flush=1 clears all valid bits at the edge; a cpu_req in that cycle is not accepted. On acceptance: latch addr/we/wdata, issue array read at cpu_addr, go LOOKUP.
- LOOKUP: hit = valid[index] && tag match. Exactly one of hit_count/miss_count increments (saturate at 0xFFFF).
  - Load hit: register cpu_rdata = word, pulse cpu_rvalid; go IDLE.
  - Load miss: beat = 0; go FILL.
  - Store hit: update data array word; go WRITE. Store miss: no allocate; go WRITE.
- FILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat}. Each mem_ack writes mem_rdata to line[beat]; if beat == offset, capture into hold register. On ack with beat = LINE_WORDS−1: set tag, set valid, drive cpu_rdata from hold (or mem_rdata if offset is last), pulse cpu_rvalid, go IDLE. Otherwise beat+1.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values; on mem_ack go IDLE.
- mem_ack while mem_req=0 ignored. mem_addr/mem_we/mem_wdata stable while mem_req=1 and no ack.
- Reset (any state, asynchronous): state IDLE, valid vector cleared, beat 0, counters 0, mem_req 0, mem_we 0, cpu_rvalid 0, cpu_rdata 0, mem_addr 0, mem_wdata 0; cpu_ready 1 once rst releases (subject to flush). In-flight request is dropped.

## Timing
- Acceptance edge E0. LOOKUP during cycle after E0. Decision at E1.
- Load hit: cpu_rvalid high for exactly the cycle after E1; cpu_ready high again after E1.
- Load miss, mem_ack held 1: FILL beats acked at E2..E(1+LINE_WORDS); cpu_rvalid in the cycle after the last ack; no further memory traffic.
- Store: mem_req rises after E1; cpu_ready returns the cycle after the ack edge.
- cpu_rvalid never asserted for stores. At most one outstanding request.

## Test plan
- Reset; memory model returns (addr[7:0] ^ 0xA5), ack every cycle; load 0x1234 -> reads 0x1234..0x1237 in order, single cpu_rvalid with 0x91, miss_count=1.
- Then load 0x1236 -> no mem_req, cpu_rvalid the cycle after E1 with 0x93, hit_count=1; mem_ack delayed 3 cycles on a fill -> mem_addr held stable throughout.
- Store 0x1235=0x5A (hit) -> one mem write 0x1235/0x5A, load 0x1235 returns 0x5A without mem_req; store 0x4000=0x77 (miss) -> mem write only, following load 0x4000 misses.
- Conflict: load 0x1234, load 0x2234 (same index, tag 0x22), load 0x1234 -> three misses, three fills.
- Flush asserted in IDLE with cpu_req=1 -> cpu_ready=0 that cycle, no acceptance; subsequent load 0x1234 misses.
- rst asserted mid-fill after 2 acks -> mem_req low immediately, counters 0, cpu_rvalid never pulses; after release load 0x1234 misses and fills all 4 words.
